// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-controller bus: program control, branch LUT write port,
// ROM address/data and run status.
interface inst_fetch_ctrl_if #(
    parameter int A = 10,
    parameter int W = 9
);
    logic         Start;
    logic         Stall;
    logic         BranchTaken;
    logic [2:0]   BranchSel;
    logic         LutWe;
    logic [2:0]   LutIdx;
    logic [A-1:0] LutData;
    logic [W-1:0] InstIn;
    logic [A-1:0] InstAddress;
    logic         InstValid;
    logic         Done;
    logic [15:0]  InstCount;

    modport master (
        output Start, Stall, BranchTaken, BranchSel,
        output LutWe, LutIdx, LutData, InstIn,
        input  InstAddress, InstValid, Done, InstCount
    );

    modport slave (
        input  Start, Stall, BranchTaken, BranchSel,
        input  LutWe, LutIdx, LutData, InstIn,
        output InstAddress, InstValid, Done, InstCount
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Program-counter sequencer: drives the ROM address, follows branches
// through an 8-entry target LUT and stops on the halt word.
module inst_fetch_ctrl #(
    parameter int             A         = 10,
    parameter int             W         = 9,
    parameter logic [W-1:0]   HALT_WORD = '1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    inst_fetch_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic         done_q, done_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [A-1:0] lut_q [8];
    logic [A-1:0] lut_d [8];
    logic [15:0]  cnt_inc;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        lut_d   = lut_q;

        if (bus.LutWe) begin
            lut_d[bus.LutIdx] = bus.LutData;
        end

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.Start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // Branch reads lut_q so a same-cycle write is not seen
                if (bus.Stall) begin
                    state_d = S_RUN;
                end else if (bus.InstIn == HALT_WORD) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                end else if (bus.BranchTaken) begin
                    pc_d  = lut_q[bus.BranchSel];
                    cnt_d = cnt_inc;
                end else begin
                    pc_d  = pc_q + A'(1);
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 8; i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.InstValid   = (state_q == S_RUN) && !bus.Stall;
    assign bus.Done        = done_q;
    assign bus.InstCount   = cnt_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios then random traffic,
// all compared against a behavioural program-run model.
module tb_inst_fetch_ctrl;
    localparam int         A    = 10;
    localparam int         W    = 9;
    localparam int         DEPTH = 1 << A;
    localparam logic [W-1:0] HALT = '1;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    inst_fetch_ctrl_if #(.A(A), .W(W)) bus ();

    inst_fetch_ctrl #(
        .A(A), .W(W), .HALT_WORD(HALT)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    logic [W-1:0] rom [DEPTH];
    assign bus.InstIn = rom[bus.InstAddress];

    int errors = 0;
    int checks = 0;

    // Model: running / halted flags, PC, retired count, target table
    bit m_run;
    bit m_done;
    int m_pc;
    int m_cnt;
    int m_lut [8];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(string t);
        check({t, ".pc"}, 32'(bus.InstAddress), 32'(m_pc));
        check({t, ".done"}, 32'(bus.Done), 32'(m_done));
        check({t, ".cnt"}, 32'(bus.InstCount), 32'(m_cnt));
        check({t, ".valid"}, 32'(bus.InstValid),
              32'(m_run && !bus.Stall));
    endtask

    task automatic model_clear();
        m_run  = 0;
        m_done = 0;
        m_pc   = 0;
        m_cnt  = 0;
        foreach (m_lut[i]) m_lut[i] = 0;
    endtask

    task automatic idle();
        bus.Start       = 0;
        bus.Stall       = 0;
        bus.BranchTaken = 0;
        bus.BranchSel   = 0;
        bus.LutWe       = 0;
        bus.LutIdx      = 0;
        bus.LutData     = 0;
    endtask

    task automatic rom_nop();
        foreach (rom[i]) rom[i] = '0;
    endtask

    // One clock: predict from the rules, clock, then compare
    task automatic step(string t);
        int npc;
        int ncnt;
        bit nrun;
        bit ndone;
        bit we;
        int widx;
        int wdat;
        logic [W-1:0] iw;
        npc   = m_pc;
        ncnt  = m_cnt;
        nrun  = m_run;
        ndone = m_done;
        we    = bus.LutWe;
        widx  = int'(bus.LutIdx);
        wdat  = int'(bus.LutData);
        iw    = rom[m_pc];
        if (!m_run) begin
            if (bus.Start) begin
                nrun  = 1;
                ndone = 0;
                npc   = 0;
                ncnt  = 0;
            end
        end else if (!bus.Stall) begin
            if (iw == HALT) begin
                nrun  = 0;
                ndone = 1;
            end else begin
                if (bus.BranchTaken) npc = m_lut[bus.BranchSel];
                else                 npc = (m_pc + 1) % DEPTH;
                if (ncnt < 65535) ncnt = ncnt + 1;
            end
        end
        @(posedge Clk);
        #1;
        m_pc   = npc;
        m_cnt  = ncnt;
        m_run  = nrun;
        m_done = ndone;
        if (we) m_lut[widx] = wdat;
        check_all(t);
    endtask

    task automatic async_reset(string t);
        #2 Reset_n = 1'b0;
        #1;
        model_clear();
        check_all(t);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        idle();
        rom_nop();
        model_clear();
        #1;
        check_all("reset");
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Straight-line program ending in the halt word
        rom[4] = HALT;
        bus.Start = 1;
        step("t1_start");
        bus.Start = 0;
        check("t1_pc0", 32'(bus.InstAddress), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step("t1_run");
            check("t1_seq", 32'(bus.InstAddress), 32'(i));
        end
        step("t1_halt");
        check("t1_done", 32'(bus.Done), 32'd1);
        check("t1_cnt", 32'(bus.InstCount), 32'd4);
        step("t1_hold");
        check("t1_pc4", 32'(bus.InstAddress), 32'd4);

        // Branch through a freshly written LUT entry
        bus.LutWe = 1; bus.LutIdx = 3; bus.LutData = 10'h200;
        step("t2_wr");
        bus.LutWe = 0;
        rom[4] = '0;
        bus.Start = 1;
        step("t2_start");
        bus.Start = 0;
        step("t2_a");
        step("t2_b");
        bus.BranchTaken = 1; bus.BranchSel = 3;
        step("t2_br");
        bus.BranchTaken = 0;
        check("t2_tgt", 32'(bus.InstAddress), 32'h200);
        check("t2_cnt", 32'(bus.InstCount), 32'd3);

        // Stall for three cycles at PC 5
        rom[10'h201] = HALT;
        step("t3_a");
        step("t3_halt");
        bus.Start = 1;
        step("t3_start");
        bus.Start = 0;
        for (int i = 0; i < 5; i++) step("t3_run");
        bus.Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step("t3_stall");
            check("t3_pc", 32'(bus.InstAddress), 32'd5);
            check("t3_val", 32'(bus.InstValid), 32'd0);
            check("t3_cnt", 32'(bus.InstCount), 32'd5);
        end
        bus.Stall = 0;
        step("t3_resume");
        check("t3_pc6", 32'(bus.InstAddress), 32'd6);

        // PC wrap, then halt wins over a branch
        bus.LutWe = 1; bus.LutIdx = 5; bus.LutData = 10'h3FF;
        step("t4_wr");
        bus.LutWe = 0;
        bus.BranchTaken = 1; bus.BranchSel = 5;
        step("t4_br");
        bus.BranchTaken = 0;
        check("t4_top", 32'(bus.InstAddress), 32'h3FF);
        step("t4_wrap");
        check("t4_zero", 32'(bus.InstAddress), 32'd0);
        rom[1] = HALT;
        step("t4_one");
        bus.BranchTaken = 1; bus.BranchSel = 5;
        step("t4_halt");
        bus.BranchTaken = 0;
        check("t4_nobr", 32'(bus.InstAddress), 32'd1);
        check("t4_done", 32'(bus.Done), 32'd1);

        // Asynchronous reset in the middle of a run
        rom[1] = '0;
        bus.Start = 1;
        step("t5_start");
        bus.Start = 0;
        for (int i = 0; i < 7; i++) step("t5_run");
        check("t5_pc7", 32'(bus.InstAddress), 32'd7);
        async_reset("t5_rst");
        check("t5_pc", 32'(bus.InstAddress), 32'd0);
        check("t5_val", 32'(bus.InstValid), 32'd0);
        bus.Start = 1;
        step("t5_start2");
        bus.Start = 0;
        bus.BranchTaken = 1; bus.BranchSel = 3;
        step("t5_lut0");
        bus.BranchTaken = 0;
        check("t5_lutz", 32'(bus.InstAddress), 32'd0);

        // Same-cycle LUT write vs branch; Start in RUN and HALTED
        rom[10'h201] = '0;
        rom[10'h202] = HALT;
        bus.LutWe = 1; bus.LutIdx = 3; bus.LutData = 10'h200;
        step("t6_wr");
        bus.LutData = 10'h100;
        bus.BranchTaken = 1; bus.BranchSel = 3;
        step("t6_race");
        bus.LutWe = 0; bus.BranchTaken = 0;
        check("t6_old", 32'(bus.InstAddress), 32'h200);
        bus.Start = 1;
        step("t6_ign");
        bus.Start = 0;
        check("t6_run", 32'(bus.InstAddress), 32'h201);
        step("t6_a");
        step("t6_halt");
        check("t6_done", 32'(bus.Done), 32'd1);
        bus.Start = 1;
        step("t6_restart");
        bus.Start = 0;
        check("t6_pc0", 32'(bus.InstAddress), 32'd0);
        check("t6_cnt0", 32'(bus.InstCount), 32'd0);

        // Random programs and control traffic
        foreach (rom[i]) begin
            if ($urandom_range(0, 99) < 3) rom[i] = HALT;
            else rom[i] = W'($urandom_range(0, 510));
        end
        for (int c = 0; c < 3000; c++) begin
            bus.Start       = ($urandom_range(0, 99) < 8);
            bus.Stall       = ($urandom_range(0, 99) < 20);
            bus.BranchTaken = ($urandom_range(0, 99) < 20);
            bus.BranchSel   = 3'($urandom_range(0, 7));
            bus.LutWe       = ($urandom_range(0, 99) < 15);
            bus.LutIdx      = 3'($urandom_range(0, 7));
            bus.LutData     = A'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 499) == 0) begin
                idle();
                async_reset("rnd_rst");
            end else begin
                step("rnd");
            end
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
